// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - b_in, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the registered signed-overflow output ovf.
`timescale 1ns/1ps

module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic [N-1:0] d,
    output logic         b_out,
    output logic         busy,
    output logic         done
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     r_q, r_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    assign diff = a_q[0] ^ b_q[0] ^ br_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = b_in;
                    cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    sa_d    = a[N-1];
                    sb_d    = b[N-1];
`endif
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
                r_d   = {diff, r_q[N-1:1]};
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // The bit produced on this edge is the result's sign bit.
                    ovf_d   = (sa_q ^ sb_q) & (sa_q ^ diff);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign d     = r_q;
    assign b_out = br_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (N=4); ovf is checked when the overflow macro is defined.
`timescale 1ns/1ps

module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic [N-1:0] d;
    logic         b_out;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .d     (d),
        .b_out (b_out),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept at E0, busy through E_{N-1}, done at E_N, then IDLE with d held.
    task automatic run_op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic bi, input logic [N-1:0] exp_d, input logic exp_bo);
        a = av; b = bv; b_in = bi; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv; b_in = ~bi;
        for (int k = 0; k < N; k++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_phase cyc=%0d busy=%b done=%b required busy=1 done=0", name, k, busy, done);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || d !== exp_d || b_out !== exp_bo) begin
            bad++;
            $display("FAIL %s result done=%b busy=%b d=%0d b_out=%b required done=1 busy=0 d=%0d b_out=%b",
                     name, done, busy, d, b_out, exp_d, exp_bo);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || d !== exp_d || b_out !== exp_bo) begin
            bad++;
            $display("FAIL %s hold done=%b busy=%b d=%0d b_out=%b required done=0 busy=0 d=%0d b_out=%b",
                     name, done, busy, d, b_out, exp_d, exp_bo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        tick();
        tick();
        total++;
        if (d !== '0 || b_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state d=%0d b_out=%b busy=%b done=%b required all 0", d, b_out, busy, done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_op("basic_5m3", 4'd5, 4'd3, 1'b0, 4'd2, 1'b0);
        run_op("bin_9m4m1", 4'd9, 4'd4, 1'b1, 4'd4, 1'b0);
    endtask

    task automatic test_borrow();
        run_op("borrow_3m5",   4'd3,  4'd5,  1'b0, 4'd14, 1'b1);
        run_op("borrow_0m0m1", 4'd0,  4'd0,  1'b1, 4'd15, 1'b1);
        run_op("equal_15m15",  4'd15, 4'd15, 1'b0, 4'd0,  1'b0);
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        a = 4'd9; b = 4'd4; b_in = 1'b0; start = 1'b1;
        tick();                                   // E0 accepts 9-4
        start = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            if (c == 2) begin a = 4'd1; b = 4'd1; start = 1'b1; end
            else start = 1'b0;
            tick();                               // edge E_c
            if (done) pulses++;
            total++;
            if (c < N && (busy !== 1'b1 || done !== 1'b0)) begin
                bad++;
                $display("FAIL ignored_start busy E%0d busy=%b done=%b required busy=1 done=0", c, busy, done);
            end else if (c == N && (done !== 1'b1 || d !== 4'd5)) begin
                bad++;
                $display("FAIL ignored_start result E%0d done=%b d=%0d required done=1 d=5", c, done, d);
            end else if (c > N && (busy !== 1'b0 || done !== 1'b0 || d !== 4'd5)) begin
                bad++;
                $display("FAIL ignored_start after E%0d busy=%b done=%b d=%0d required 0 0 5", c, busy, done, d);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL ignored_start pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int last_pulse = -1;
        int pulses = 0;
        a = 4'd7; b = 4'd2; b_in = 1'b0; start = 1'b1;
        tick();                                   // E0
        for (int c = 1; c <= 3 * (N + 1); c++) begin
            tick();
            if (done) begin
                pulses++;
                total++;
                if (d !== 4'd5 || b_out !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b value E%0d d=%0d b_out=%b required d=5 b_out=0", c, d, b_out);
                end
                total++;
                if (c - last_pulse != N + 1 && last_pulse >= 0) begin
                    bad++;
                    $display("FAIL b2b spacing E%0d gap=%0d required %0d", c, c - last_pulse, N + 1);
                end else if (last_pulse < 0 && c != N) begin
                    bad++;
                    $display("FAIL b2b first_pulse at E%0d required E%0d", c, N);
                end
                last_pulse = c;
                if (pulses == 3) start = 1'b0;
            end else if (pulses == 3) begin
                break;
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b pulses=%0d required 3", pulses);
        end
        // The edge after the third pulse saw start=0: expect IDLE with d held.
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== 4'd5) begin
            bad++;
            $display("FAIL b2b idle_hold busy=%b done=%b d=%0d required 0 0 5", busy, done, d);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        a = 4'd11; b = 4'd3; b_in = 1'b0; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (d !== '0 || b_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid d=%0d b_out=%b busy=%b done=%b required all 0", d, b_out, busy, done);
        end
        start = 1'b1;                             // reset must win over start
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_vs_start busy=%b done=%b required 0 0", busy, done);
        end
        start = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            tick();
            if (done || busy) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid spurious_activity cycles=%0d required 0", pulses);
        end
        run_op("after_reset_6m1", 4'd6, 4'd1, 1'b0, 4'd5, 1'b0);
    endtask

    task automatic test_overflow();
        run_op("ovf_8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_8m1 ovf=%b required 1", ovf);
        end
`endif
        run_op("ovf_4m2", 4'd4, 4'd2, 1'b0, 4'd2, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_4m2 ovf=%b required 0", ovf);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
